// File: rtl/config_pkg.sv
// Core configuration type plus register-address and write-back source definitions
// shared by the issue, write-back and register-file blocks.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      logic        E_SUPPORTED;
   } config_t;

   localparam config_t DEFAULT_CONF = '{XLEN: 32, E_SUPPORTED: 1'b0};

   localparam int REG_ADDR_W = 5;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum int {
      WB_ALU = 0,
      WB_LSU = 1,
      WB_MDU = 2
   } wb_src_e;

   // x0 is hardwired, and RV32E has only 16 architectural registers.
   function automatic logic reg_live(input reg_addr_t a, input int unsigned numregs);
      return (a != '0) && (32'(a) < numregs);
   endfunction

endpackage

// File: rtl/core_rr_arbiter.sv
// Generic N-way round-robin arbiter: grants the first requester at or after the
// pointer, and the pointer advances past the winner only when a grant is made.
module core_rr_arbiter #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         i_req,
   output logic [N-1:0]         o_gnt,
   output logic                 o_gnt_valid,
   output logic [$clog2(N)-1:0] o_gnt_idx
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_cand;
   logic          w_found;
   int            w_sum;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
      w_found = 1'b0;
      w_idx   = r_ptr;
      w_cand  = r_ptr;
      w_sum   = 0;
      for (int i = 0; i < N; i++) begin
         w_sum = int'(r_ptr) + i;
         if (w_sum >= N) w_sum = w_sum - N;
         w_cand = PW'(w_sum);
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
      o_gnt        = '0;
      o_gnt[w_idx] = w_found;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
      end
   end

   assign o_gnt_valid = w_found;
   assign o_gnt_idx   = w_idx;

endmodule

// File: rtl/core_wb_scheduler.sv
// Write-back scheduler: round-robin sharing of the regfile write port between
// execution units, plus a busy scoreboard that stalls issue on RAW/WAW hazards.
module core_wb_scheduler
   import config_pkg::*;
#(
   parameter config_t CONF    = DEFAULT_CONF,
   parameter int      NUM_SRC = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         issue_valid,
   input  logic [4:0]                   issue_rs1,
   input  logic [4:0]                   issue_rs2,
   input  logic [4:0]                   issue_rd,
   input  logic                         issue_we,
   output logic                         issue_stall,
   input  logic [NUM_SRC-1:0]           wb_valid,
   input  logic [NUM_SRC*5-1:0]         wb_rd,
   input  logic [NUM_SRC*CONF.XLEN-1:0] wb_data,
   output logic [NUM_SRC-1:0]           wb_ready,
   output logic [4:0]                   rf_a2,
   output logic [CONF.XLEN-1:0]         rf_wd2,
   output logic                         rf_we2
);

   localparam int          XLEN    = int'(CONF.XLEN);
   localparam int unsigned NUMREGS = CONF.E_SUPPORTED ? 16 : 32;
   localparam int          SW      = $clog2(NUM_SRC);

   logic            w_gnt_valid;
   logic [SW-1:0]   w_gnt_idx;
   reg_addr_t       w_sel_rd;
   logic [XLEN-1:0] w_sel_data;
   logic            w_sel_live;
   logic            w_rs1_live;
   logic            w_rs2_live;
   logic            w_rd_live;
   logic            w_set;
   logic [31:0]     w_busy_nxt;

   reg_addr_t       r_a2;
   logic [XLEN-1:0] r_wd2;
   logic            r_we2;
   logic [31:0]     r_busy;

   core_rr_arbiter #(.N(NUM_SRC)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (wb_valid),
      .o_gnt       (wb_ready),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   assign w_sel_rd   = wb_rd[int'(w_gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
   assign w_sel_data = wb_data[int'(w_gnt_idx)*XLEN +: XLEN];
   assign w_sel_live = reg_live(w_sel_rd, NUMREGS);

   assign w_rs1_live = reg_live(issue_rs1, NUMREGS);
   assign w_rs2_live = reg_live(issue_rs2, NUMREGS);
   assign w_rd_live  = reg_live(issue_rd, NUMREGS);

   // No bypass: a register stays busy through the cycle its value is being written.
   assign issue_stall = issue_valid &&
                        ((w_rs1_live && r_busy[issue_rs1]) ||
                         (w_rs2_live && r_busy[issue_rs2]) ||
                         (issue_we && w_rd_live && r_busy[issue_rd]));

   assign w_set = issue_valid && !issue_stall && issue_we && w_rd_live;

   // Dead writes (x0, out-of-range) are still consumed, only the enable is suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a2  <= '0;
         r_wd2 <= '0;
         r_we2 <= 1'b0;
      end else begin
         r_we2 <= w_gnt_valid && w_sel_live;
         if (w_gnt_valid) begin
            r_a2  <= w_sel_rd;
            r_wd2 <= w_sel_data;
         end
      end
   end

   // Clear first, then set, so a same-index collision resolves to busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_we2) w_busy_nxt[r_a2] = 1'b0;
      if (w_set) w_busy_nxt[issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the scoreboard is plain flops, so it is reset with everything else, unlike a RAM.
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

   assign rf_a2  = r_a2;
   assign rf_wd2 = r_wd2;
   assign rf_we2 = r_we2;

endmodule

// File: tb/tb_core_wb_scheduler.sv
// Self-checking bench for core_wb_scheduler: vector table, directed corner sequences
// and randomized traffic against a behavioural scoreboard/arbiter model.
module tb_core_wb_scheduler;
   import config_pkg::*;

   localparam config_t CONF_I = '{XLEN: 32, E_SUPPORTED: 1'b0};
   localparam config_t CONF_E = '{XLEN: 32, E_SUPPORTED: 1'b1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid, issue_we;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic [2:0]  wb_valid;
   logic [14:0] wb_rd;
   logic [95:0] wb_data;

   logic        issue_stall, rf_we2;
   logic [2:0]  wb_ready;
   logic [4:0]  rf_a2;
   logic [31:0] rf_wd2;
   logic        e_stall, e_we2;
   logic [2:0]  e_ready;
   logic [4:0]  e_a2;
   logic [31:0] e_wd2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   core_wb_scheduler #(.CONF(CONF_I), .NUM_SRC(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_we(issue_we), .issue_stall(issue_stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
      .rf_a2(rf_a2), .rf_wd2(rf_wd2), .rf_we2(rf_we2)
   );

   core_wb_scheduler #(.CONF(CONF_E), .NUM_SRC(3)) dut_e (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_we(issue_we), .issue_stall(e_stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(e_ready),
      .rf_a2(e_a2), .rf_wd2(e_wd2), .rf_we2(e_we2)
   );

   typedef struct {
      logic        iv;
      logic [4:0]  rs1, rs2, rd;
      logic        we;
      logic [2:0]  wv;
      logic [14:0] wrd;
      logic [95:0] wdat;
      logic        x_stall;
      logic [2:0]  x_ready;
      logic        x_we2;
      logic [4:0]  x_a2;
      logic [31:0] x_wd2;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      issue_valid = 1'b0; issue_we = 1'b0;
      issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      wb_valid = '0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic we);
      issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_we = we;
   endtask

   task automatic set_src(input int s, input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb_valid[s]      = v;
      wb_rd[s*5 +: 5]  = rd;
      wb_data[s*32 +: 32] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_busy[32];
   int          m_ptr;
   logic        m_we2;
   logic [4:0]  m_a2;
   logic [31:0] m_wd2;
   bit          p_v[3];
   logic [4:0]  p_rd[3];
   logic [31:0] p_d[3];

   function automatic bit live32(input logic [4:0] a);
      return a != 5'd0;
   endfunction

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_ptr = 0; m_we2 = 1'b0; m_a2 = '0; m_wd2 = '0;
      for (int s = 0; s < 3; s++) begin
         p_v[s] = 1'b0; p_rd[s] = '0; p_d[s] = '0;
      end
   endtask

   initial begin
      int          g;
      logic [2:0]  x_ready;
      logic        x_stall;

      clear_inputs();
      vt[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000, 15'd0, 96'd0,
                1'b0, 3'b000, 1'b0, 5'd0, 32'h0};
      vt[1] = '{1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h11},
                1'b1, 3'b001, 1'b0, 5'd0, 32'h0};
      vt[2] = '{1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 3'b000, 15'd0, 96'd0,
                1'b1, 3'b000, 1'b1, 5'd3, 32'h11};
      vt[3] = '{1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 3'b000, 15'd0, 96'd0,
                1'b0, 3'b000, 1'b0, 5'd3, 32'h11};
      vt[4] = '{1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 3'b111, {5'd0, 5'd4, 5'd5}, {32'h66, 32'h44, 32'h55},
                1'b1, 3'b010, 1'b0, 5'd3, 32'h11};
      vt[5] = '{1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 3'b101, {5'd0, 5'd4, 5'd5}, {32'h66, 32'h44, 32'h55},
                1'b1, 3'b100, 1'b1, 5'd4, 32'h44};
      vt[6] = '{1'b1, 5'd0, 5'd4, 5'd0, 1'b1, 3'b001, {5'd0, 5'd4, 5'd5}, {32'h66, 32'h44, 32'h55},
                1'b0, 3'b001, 1'b0, 5'd0, 32'h66};
      vt[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 15'd0, 96'd0,
                1'b0, 3'b000, 1'b1, 5'd5, 32'h55};

      // Reset state
      do_reset();
      check("reset_we2", 64'(rf_we2), 64'd0);
      check("reset_a2", 64'(rf_a2), 64'd0);
      check("reset_wd2", 64'(rf_wd2), 64'd0);
      check("reset_ready", 64'(wb_ready), 64'd0);
      check("reset_stall", 64'(issue_stall), 64'd0);

      // Vector table: RAW hold/release, round-robin pointer, x0 write-back
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         set_issue(vt[i].iv, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].we);
         wb_valid = vt[i].wv; wb_rd = vt[i].wrd; wb_data = vt[i].wdat;
         @(negedge clk);
         check($sformatf("vec%0d_stall", i), 64'(issue_stall), 64'(vt[i].x_stall));
         check($sformatf("vec%0d_ready", i), 64'(wb_ready), 64'(vt[i].x_ready));
         check($sformatf("vec%0d_we2", i), 64'(rf_we2), 64'(vt[i].x_we2));
         check($sformatf("vec%0d_a2", i), 64'(rf_a2), 64'(vt[i].x_a2));
         check($sformatf("vec%0d_wd2", i), 64'(rf_wd2), 64'(vt[i].x_wd2));
      end

      // Single write, two-edge latency
      do_reset();
      next_cycle();
      set_src(0, 1'b1, 5'd7, 32'hDEADBEEF);
      @(negedge clk);
      check("single_ready", 64'(wb_ready), 64'b001);
      check("single_we2_early", 64'(rf_we2), 64'd0);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("single_we2", 64'(rf_we2), 64'd1);
      check("single_a2", 64'(rf_a2), 64'd7);
      check("single_wd2", 64'(rf_wd2), 64'hDEADBEEF);
      check("single_ready_drop", 64'(wb_ready), 64'd0);

      // Round-robin fairness with all sources requesting
      do_reset();
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(10 + s), 32'(i));
         @(negedge clk);
         check($sformatf("rr_grant%0d", i), 64'(wb_ready), 64'(3'b001 << (i % 3)));
      end

      // x0 and E-mode handling
      do_reset();
      next_cycle();
      set_issue(1'b1, 5'd0, 5'd0, 5'd20, 1'b1);
      @(negedge clk);
      check("e_first_stall", 64'(e_stall), 64'd0);
      next_cycle();
      set_issue(1'b1, 5'd20, 5'd0, 5'd20, 1'b1);
      set_src(0, 1'b1, 5'd20, 32'hAA);
      @(negedge clk);
      check("e_rd20_stall", 64'(e_stall), 64'd0);
      check("i_rd20_stall", 64'(issue_stall), 64'd1);
      check("e_rd20_ready", 64'(e_ready), 64'b001);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("e_rd20_we2", 64'(e_we2), 64'd0);
      check("i_rd20_we2", 64'(rf_we2), 64'd1);
      next_cycle();
      set_src(0, 1'b1, 5'd0, 32'hBB);
      @(negedge clk);
      check("x0_ready", 64'(wb_ready), 64'b001);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("x0_we2", 64'(rf_we2), 64'd0);
      check("x0_a2", 64'(rf_a2), 64'd0);

      // WAW against a pending LSU load
      do_reset();
      next_cycle();
      set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
      @(negedge clk);
      check("waw_first_stall", 64'(issue_stall), 64'd0);
      next_cycle();
      set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
      set_src(WB_LSU, 1'b1, 5'd9, 32'h1234);
      @(negedge clk);
      check("waw_stall_req", 64'(issue_stall), 64'd1);
      check("waw_ready", 64'(wb_ready), 64'b010);
      next_cycle();
      set_src(WB_LSU, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      check("waw_stall_commit", 64'(issue_stall), 64'd1);
      check("waw_we2", 64'(rf_we2), 64'd1);
      check("waw_a2", 64'(rf_a2), 64'd9);
      next_cycle();
      @(negedge clk);
      check("waw_stall_release", 64'(issue_stall), 64'd0);
      next_cycle();
      set_issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
      @(negedge clk);
      check("waw_rebusy", 64'(issue_stall), 64'd1);

      // Reset mid-traffic with busy[5] set and rf_we2 high
      do_reset();
      next_cycle();
      set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
      next_cycle();
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      set_src(0, 1'b1, 5'd6, 32'h77);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("mid_pre_we2", 64'(rf_we2), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_we2", 64'(rf_we2), 64'd0);
      check("mid_a2", 64'(rf_a2), 64'd0);
      check("mid_wd2", 64'(rf_wd2), 64'd0);
      check("mid_ready", 64'(wb_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      set_issue(1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
      @(negedge clk);
      check("mid_rd5_stall", 64'(issue_stall), 64'd0);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         next_cycle();
         for (int s = 0; s < 3; s++) begin
            if (!p_v[s] && ($urandom_range(0, 1) == 1)) begin
               p_v[s] = 1'b1; p_rd[s] = pick_reg(); p_d[s] = $urandom;
            end
            set_src(s, p_v[s], p_rd[s], p_d[s]);
         end
         set_issue(1'($urandom_range(0, 1)), pick_reg(), pick_reg(), pick_reg(),
                   1'($urandom_range(0, 1)));
         @(negedge clk);
         g = -1;
         for (int k = 0; k < 3; k++)
            if (g < 0 && p_v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
         x_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
         x_stall = issue_valid && ((live32(issue_rs1) && m_busy[issue_rs1]) ||
                                   (live32(issue_rs2) && m_busy[issue_rs2]) ||
                                   (issue_we && live32(issue_rd) && m_busy[issue_rd]));
         check("rnd_ready", 64'(wb_ready), 64'(x_ready));
         check("rnd_stall", 64'(issue_stall), 64'(x_stall));
         check("rnd_we2", 64'(rf_we2), 64'(m_we2));
         check("rnd_a2", 64'(rf_a2), 64'(m_a2));
         check("rnd_wd2", 64'(rf_wd2), 64'(m_wd2));
         if (m_we2) m_busy[m_a2] = 1'b0;
         if (issue_valid && !x_stall && issue_we && live32(issue_rd)) m_busy[issue_rd] = 1'b1;
         if (g >= 0) begin
            m_a2 = p_rd[g]; m_wd2 = p_d[g]; m_we2 = live32(p_rd[g]);
            m_ptr = (g + 1) % 3;
            p_v[g] = 1'b0;
         end else begin
            m_we2 = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
